// File: rtl/config_chain_sequencer.sv
// Serialises configuration words LSB-first into one of NCOL fabric columns, with an optional commit strobe.
// Define CFG_SEQ_CHECKSUM_EN to enable the running XOR checksum of accepted words.
module config_chain_sequencer #(
  parameter int NCOL   = 8,
  parameter int WORD_W = 32,
  parameter int COL_W  = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic [COL_W-1:0]  s_col,
  input  logic              s_last,
  input  logic              abort,
  output logic [NCOL-1:0]   cfg_shift,
  output logic [NCOL-1:0]   cfg_set,
  output logic              cfg_cen,
  output logic              busy,
  output logic [15:0]       words_done,
  output logic              err,
  output logic [WORD_W-1:0] checksum
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SET
  } state_e;

  state_e            state_q;
  logic [WORD_W-1:0] word_q;
  logic [COL_W-1:0]  col_q;
  logic              last_q;
  logic              col_ok_q;
  logic [BIT_W-1:0]  bit_q;
  logic [NCOL-1:0]   cfg_shift_q;
  logic [NCOL-1:0]   cfg_set_q;
  logic              cfg_cen_q;
  logic [15:0]       words_done_q;
  logic              err_q;

  logic accept;
  logic s_col_ok;
  logic last_bit;

  // Ready is gated by rst_n so it stays low for the whole reset assertion.
  assign s_ready  = rst_n && (state_q == IDLE);
  assign accept   = s_valid && s_ready;
  assign s_col_ok = (int'(s_col) < NCOL);
  assign last_bit = (bit_q == BIT_W'(WORD_W - 1));

  function automatic logic [NCOL-1:0] col_onehot(input logic [COL_W-1:0] c, input logic ok);
    logic [NCOL-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NCOL; i++) begin
      v[i] = ok && (32'(c) == i);
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      col_q        <= '0;
      last_q       <= 1'b0;
      col_ok_q     <= 1'b0;
      bit_q        <= '0;
      cfg_shift_q  <= '0;
      cfg_set_q    <= '0;
      cfg_cen_q    <= 1'b0;
      words_done_q <= '0;
      err_q        <= 1'b0;
    end else begin
      cfg_set_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            // Bit 0 is presented straight away; word_q holds the bits still to go.
            word_q      <= s_data >> 1;
            col_q       <= s_col;
            last_q      <= s_last;
            col_ok_q    <= s_col_ok;
            bit_q       <= '0;
            cfg_shift_q <= s_data[0] ? col_onehot(s_col, s_col_ok) : '0;
            cfg_cen_q   <= s_col_ok;
            state_q     <= SHIFT;
            if (!s_col_ok) begin
              err_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (abort) begin
            cfg_shift_q <= '0;
            cfg_cen_q   <= 1'b0;
            state_q     <= IDLE;
          end else if (last_bit) begin
            cfg_shift_q  <= '0;
            cfg_cen_q    <= 1'b0;
            words_done_q <= words_done_q + 16'd1;
            if (last_q) begin
              cfg_set_q <= col_onehot(col_q, col_ok_q);
              state_q   <= SET;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            bit_q       <= bit_q + 1'b1;
            word_q      <= word_q >> 1;
            cfg_shift_q <= word_q[0] ? col_onehot(col_q, col_ok_q) : '0;
          end
        end
        SET: begin
          state_q <= IDLE;
        end
        default: begin
          cfg_shift_q <= '0;
          cfg_cen_q   <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cfg_shift  = cfg_shift_q;
  assign cfg_set    = cfg_set_q;
  assign cfg_cen    = cfg_cen_q;
  assign busy       = (state_q != IDLE);
  assign words_done = words_done_q;
  assign err        = err_q;

`ifdef CFG_SEQ_CHECKSUM_EN
  logic [WORD_W-1:0] checksum_q;
  logic              set_issue;

  // Cleared on the same edge that launches the commit strobe, so it reads 0 during the pulse.
  assign set_issue = (state_q == SHIFT) && !abort && last_bit && last_q && col_ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (set_issue) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q ^ s_data;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_config_chain_sequencer.sv
// Scoreboard bench for config_chain_sequencer: per-cycle expected traces from a word-level model,
// plus a tiny fast-clocked instance that drives words_done through its 16-bit wrap.
module tb_config_chain_sequencer;

  localparam int NCOL   = 8;
  localparam int WORD_W = 32;
  localparam int COL_W  = 4;
`ifdef CFG_SEQ_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic [COL_W-1:0]  s_col;
  logic              s_last;
  logic              abort;
  logic [NCOL-1:0]   cfg_shift;
  logic [NCOL-1:0]   cfg_set;
  logic              cfg_cen;
  logic              busy;
  logic [15:0]       words_done;
  logic              err;
  logic [WORD_W-1:0] checksum;

  always #5 clk = ~clk;

  config_chain_sequencer #(.NCOL(NCOL), .WORD_W(WORD_W), .COL_W(COL_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_col(s_col), .s_last(s_last), .abort(abort), .cfg_shift(cfg_shift), .cfg_set(cfg_set),
    .cfg_cen(cfg_cen), .busy(busy), .words_done(words_done), .err(err), .checksum(checksum)
  );

  // Wrap instance: one-bit words so each word costs only two cycles.
  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        w_valid;
  logic        w_ready;
  logic [0:0]  w_data = 1'b1;
  logic [0:0]  w_col = 1'b0;
  logic        w_last = 1'b0;
  logic        w_abort = 1'b0;
  logic [1:0]  w_shift;
  logic [1:0]  w_set;
  logic        w_cen;
  logic        w_busy;
  logic [15:0] w_wd;
  logic        w_err;
  logic [0:0]  w_csum;
  bit          wrap_done = 1'b0;

  always #1 wclk = ~wclk;

  config_chain_sequencer #(.NCOL(2), .WORD_W(1)) u_wrap (
    .clk(wclk), .rst_n(wrst_n), .s_valid(w_valid), .s_ready(w_ready), .s_data(w_data),
    .s_col(w_col), .s_last(w_last), .abort(w_abort), .cfg_shift(w_shift), .cfg_set(w_set),
    .cfg_cen(w_cen), .busy(w_busy), .words_done(w_wd), .err(w_err), .checksum(w_csum)
  );

  typedef struct {
    logic [NCOL-1:0]   shift;
    logic [NCOL-1:0]   set;
    logic              cen;
    logic [WORD_W-1:0] csum;
  } cyc_t;

  typedef struct {
    logic [15:0]       wd;
    logic              err;
    logic [WORD_W-1:0] csum;
  } stat_t;

  cyc_t  cyc_q[$];
  stat_t stat_q[$];

  int checks = 0;
  int errors = 0;

  logic [15:0]       m_wd   = '0;
  logic              m_err  = 1'b0;
  logic [WORD_W-1:0] m_csum = '0;

  bit mon_en   = 1'b0;
  bit was_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) begin
        was_busy = 1'b1;
        if (cyc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL busy_extra actual=busy expected=idle at %0t", $time);
        end else begin
          cyc_t e;
          e = cyc_q.pop_front();
          chk("cycle_out", {cfg_shift, cfg_set, cfg_cen, checksum}, {e.shift, e.set, e.cen, e.csum});
        end
      end else begin
        chk("idle_out", {cfg_shift, cfg_set, cfg_cen, s_ready}, {8'h00, 8'h00, 1'b0, 1'b1});
        if (was_busy) begin
          was_busy = 1'b0;
          chk("trace_len", 64'(cyc_q.size()), 64'd0);
          cyc_q.delete();
          if (stat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stat_missing actual=none expected=record at %0t", $time);
          end else begin
            stat_t s;
            s = stat_q.pop_front();
            chk("words_done", 64'(words_done), 64'(s.wd));
            chk("err", 64'(err), 64'(s.err));
            chk("checksum", 64'(checksum), 64'(s.csum));
          end
        end
      end
    end
  end

  // Issues one word; abort_at is the shift-cycle index (0-based, WORD_W = the cycle after the shifts) or -1.
  task automatic issue(input logic [WORD_W-1:0] data, input logic [COL_W-1:0] col,
                       input logic last, input int abort_at);
    int   n;
    bit   ok;
    bit   aborted;
    int   ncyc;
    cyc_t c;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1 at %0t", $time);
      return;
    end
    ok      = (int'(col) < NCOL);
    aborted = (abort_at >= 0) && (abort_at < WORD_W);
    if (CSUM) m_csum = m_csum ^ data;
    if (!ok) m_err = 1'b1;
    ncyc = aborted ? abort_at + 1 : WORD_W;
    for (int j = 0; j < ncyc; j++) begin
      c.shift = (ok && data[j]) ? (NCOL'(1) << col) : '0;
      c.set   = '0;
      c.cen   = ok;
      c.csum  = m_csum;
      cyc_q.push_back(c);
    end
    if (!aborted) begin
      m_wd = m_wd + 16'd1;
      if (last) begin
        if (CSUM && ok) m_csum = '0;
        c.shift = '0;
        c.set   = ok ? (NCOL'(1) << col) : '0;
        c.cen   = 1'b0;
        c.csum  = m_csum;
        cyc_q.push_back(c);
      end
    end
    stat_q.push_back('{wd: m_wd, err: m_err, csum: m_csum});
    s_valid = 1'b1;
    s_data  = data;
    s_col   = col;
    s_last  = last;
    @(negedge clk); #1;
    s_valid = 1'b0;
    s_data  = $urandom;
    s_col   = COL_W'($urandom_range(0, 15));
    s_last  = 1'($urandom);
    if (abort_at >= 0) begin
      repeat (abort_at) begin
        @(negedge clk); #1;
      end
      abort = 1'b1;
      @(negedge clk); #1;
      abort = 1'b0;
    end
  endtask

  initial begin
    wrst_n  = 1'b0;
    w_valid = 1'b0;
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      @(negedge wclk);
      w_valid = 1'b1;
      @(negedge wclk);
      w_valid = 1'b0;
    end
    @(negedge wclk);
    chk("wrap_preload", 64'(w_wd), 64'h0000_FFFF);
    w_valid = 1'b1;
    @(negedge wclk);
    w_valid = 1'b0;
    @(negedge wclk);
    chk("wrap_to_zero", 64'(w_wd), 64'd0);
    wrap_done = 1'b1;
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_col   = '0;
    s_last  = 1'b0;
    abort   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", {cfg_shift, cfg_set, cfg_cen, busy, err}, '0);
    chk("rst_words_done", 64'(words_done), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    chk("rst_ready_low", 64'(s_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 64'(s_ready), 64'd1);
    mon_en = 1'b1;

    issue(32'h0000_0005, 4'd2, 1'b0, -1);
    issue(32'h0000_0005, 4'd2, 1'b1, -1);
    issue(32'hA5A5_0000, 4'd1, 1'b0, -1);
    issue(32'h0000_5A5A, 4'd1, 1'b1, -1);
    issue($urandom, 4'd3, 1'b1, 10);
    issue($urandom, 4'd9, 1'b1, -1);
    issue($urandom, 4'd7, 1'b1, WORD_W - 1);
    issue($urandom, 4'd0, 1'b1, WORD_W);
    issue($urandom, 4'd5, 1'b0, WORD_W);

    for (int i = 0; i < 40; i++) begin
      logic [WORD_W-1:0] d;
      logic [COL_W-1:0]  col;
      logic              lst;
      int                ab;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); #1;
      end
      d   = $urandom;
      col = COL_W'($urandom_range(0, 9));
      lst = 1'($urandom);
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WORD_W)) : -1;
      issue(d, col, lst, ab);
    end

    issue($urandom, 4'd4, 1'b1, -1);
    repeat (5) begin
      @(negedge clk); #1;
    end
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {cfg_shift, cfg_set, cfg_cen, busy, err, s_ready}, '0);
    chk("midrst_words_done", 64'(words_done), 64'd0);
    chk("midrst_checksum", 64'(checksum), 64'd0);
    cyc_q.delete();
    stat_q.delete();
    m_wd   = '0;
    m_err  = 1'b0;
    m_csum = '0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_midrst", 64'(s_ready), 64'd1);
    was_busy = 1'b0;
    mon_en   = 1'b1;
    issue(32'h8000_0001, 4'd6, 1'b1, -1);
    repeat (WORD_W + 4) @(negedge clk);
    #1;
    chk("queues_drained", 64'(cyc_q.size() + stat_q.size()), 64'd0);

    wait (wrap_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_chain_sequencer.md
CONFIG_CHAIN_SEQUENCER -- requirements
Module: config_chain_sequencer

Interface
REQ-001 SHALL have parameter NCOL, default 8: number of fabric configuration columns driven.
REQ-002 SHALL have parameter WORD_W, default 32: configuration word width in bits.
REQ-003 SHALL have derived parameter COL_W = clog2(NCOL), default 3: column select width.
REQ-004 SHALL have port clk  input  1  fabric clock, single clock domain.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  configuration word offered.
REQ-007 SHALL have port s_ready  output  1  word accepted when s_valid && s_ready at a rising edge.
REQ-008 SHALL have port s_data  input  WORD_W  configuration word, shifted LSB first.
REQ-009 SHALL have port s_col  input  COL_W  target column.
REQ-010 SHALL have port s_last  input  1  final word for the column; a set pulse follows the shift.
REQ-011 SHALL have port abort  input  1  cancels the word in flight.
REQ-012 SHALL have port cfg_shift  output  NCOL  per-column serial configuration data bit.
REQ-013 SHALL have port cfg_set  output  NCOL  per-column one-cycle commit strobe.
REQ-014 SHALL have port cfg_cen  output  1  shift enable shared by all columns.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port words_done  output  16  count of fully shifted words.
REQ-017 SHALL have port err  output  1  sticky flag: a word was accepted with s_col >= NCOL.
REQ-018 SHALL have port checksum  output  WORD_W  running XOR of accepted words (see Configuration).

Function
REQ-019 SHALL implement a state machine with states IDLE, SHIFT and SET.
REQ-020 SHALL assert s_ready only in IDLE; one word in flight at most; at least one IDLE cycle between words.
REQ-021 On acceptance SHALL latch s_data, s_col and s_last, load the bit counter with 0, and enter SHIFT.
REQ-022 In SHIFT SHALL drive cfg_cen=1 and cfg_shift[col]=word[bit], with all other cfg_shift bits 0; bit 0 appears in the cycle after acceptance.
REQ-023 SHALL stay in SHIFT for exactly WORD_W cycles, then increment words_done, which wraps from 0xFFFF to 0.
REQ-024 After the final shift cycle SHALL enter SET if last=1, otherwise IDLE.
REQ-025 In SET SHALL drive cfg_set[col]=1 for exactly one cycle with cfg_cen=0, then return to IDLE.
REQ-026 SHALL hold cfg_cen=0, cfg_shift=0 and cfg_set=0 in IDLE.
REQ-027 If s_col >= NCOL, SHALL accept and sequence the word normally but with cfg_shift, cfg_set and cfg_cen held at 0, and SHALL set err; words_done still increments.
REQ-028 On abort=1 in SHIFT or SET SHALL go to IDLE at the next edge with no set pulse and no words_done increment; abort in IDLE SHALL have no effect.
REQ-029 If abort and the final shift cycle coincide, SHALL apply the abort: no increment, no SET.
REQ-030 err SHALL clear only on reset.

Reset
REQ-031 On rst_n=0 SHALL immediately force state IDLE, s_ready=0 while asserted, cfg_shift=0, cfg_set=0, cfg_cen=0, busy=0, words_done=0, err=0, checksum=0; reset mid-shift SHALL discard the word.
REQ-032 SHALL assert s_ready in the first cycle after rst_n deasserts.

Configuration
REQ-033 With macro CFG_SEQ_CHECKSUM_EN defined, checksum SHALL XOR in each accepted word at acceptance and SHALL clear to 0 in the cycle a cfg_set pulse is issued.
REQ-034 Without CFG_SEQ_CHECKSUM_EN, checksum SHALL be constant 0 and SHALL have no storage.

Verification
REQ-035 SHALL cover: after reset, s_data=0x0000_0005, s_col=2, s_last=0 -> cfg_shift[2] reads 1,0,1,0... over 32 cycles with cfg_cen=1, then IDLE; words_done=1; cfg_set=0.
REQ-036 SHALL cover: same with s_last=1 -> cfg_set=0x04 for one cycle right after the 32nd shift cycle; busy=1 for 33 cycles.
REQ-037 SHALL cover: abort at shift cycle 10 -> cfg_cen=0 next cycle, words_done unchanged, s_ready=1 in the following cycle.
REQ-038 SHALL cover: s_col=9 with NCOL=8 -> all cfg outputs 0 for 32 cycles, err=1, words_done increments.
REQ-039 SHALL cover: preload words_done=0xFFFF through 65535 words, then one more word -> words_done=0.
REQ-040 SHALL cover, with CFG_SEQ_CHECKSUM_EN: words 0xA5A5_0000 then 0x0000_5A5A (s_last=1) -> checksum=0xA5A5_5A5A before the set pulse and 0 after it; without the macro, checksum stays 0.
